icache_sa: RTL

- Parametrised, set-associative successor to the direct-mapped instruction cache.
- Sits between the instruction fetcher and the memory controller.
- Serves 32-bit instruction words on hit with 1-cycle registered latency; on miss, refills a whole line word-by-word from the memory controller.
- Adds configurable sets/ways/line size, LRU victim selection and a flush input for fence.i.

---
 rtl/icache_sa_if.sv | 43 ++++
 rtl/icache_sa.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_sa_if.sv
// icache_sa_if: fetcher-side and memory-controller-side signals of the
// set-associative instruction cache.
// slave  = the cache's view, master = the environment (fetcher + memory).
`timescale 1ns/1ps

interface icache_sa_if;
    // Fetcher side
    logic        fet_req;
    logic [31:0] pc;
    logic        flush;
    logic        instr_valid;
    logic [31:0] instr;

    // Memory-controller side
    logic        mc_ena;
    logic [31:0] mc_addr;
    logic        mc_valid;
    logic [31:0] mc_data;

    modport slave (
        input  fet_req,
        input  pc,
        input  flush,
        input  mc_valid,
        input  mc_data,
        output instr_valid,
        output instr,
        output mc_ena,
        output mc_addr
    );

    modport master (
        output fet_req,
        output pc,
        output flush,
        output mc_valid,
        output mc_data,
        input  instr_valid,
        input  instr,
        input  mc_ena,
        input  mc_addr
    );
endinterface

// File: rtl/icache_sa.sv
// icache_sa: parametrised set-associative instruction cache.
// Hits return the word one cycle after the request. Misses refill the whole
// line beat-by-beat from the memory controller, then return to IDLE so the
// fetcher's re-presented pc hits. One LRU bit per set (victim way to
// evict next) and a flush input for fence.i.
// Optional feature: define ICACHE_STATS_EN to add hit_cnt / miss_cnt outputs.
`timescale 1ns/1ps

module icache_sa #(
    parameter int SETS       = 64,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    icache_sa_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TW = 30 - OB - IB;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_REFILL = 1'b1;

    // Request address fields
    logic [OB-1:0] req_off;
    logic [IB-1:0] req_idx;
    logic [TW-1:0] req_tag;

    // Storage: not reset, only qualified by the valid bits
    logic [TW-1:0] tag_mem  [SETS][WAYS];
    logic [31:0]   data_mem [SETS][WAYS][LINE_WORDS];

    // Per-set state that is reset
    logic [WAYS-1:0] valid_q [SETS];
    logic [SETS-1:0] lru_q;

    // Control state
    logic [0:0]    state_q;
    logic [OB-1:0] beat_q;
    logic [IB-1:0] ref_idx_q;
    logic          ref_way_q;
    logic          flush_pend_q;

    // Output registers
    logic          instr_valid_q;
    logic [31:0]   instr_q;
    logic          mc_ena_q;
    logic [31:0]   mc_addr_q;

    // Lookup results
    logic          hit;
    logic          hit_way;
    logic          victim;
    logic          victim_found;
    logic          last_beat;
    logic          beat_fire;
    logic          idle_lookup;

    logic          unused_pc_bits;

    assign req_off = bus.pc[2 +: OB];
    assign req_idx = bus.pc[2+OB +: IB];
    assign req_tag = bus.pc[31 : 2+OB+IB];

    assign unused_pc_bits = ^bus.pc[1:0];

    assign last_beat   = (beat_q == OB'(LINE_WORDS - 1));
    assign beat_fire   = rdy && (state_q == S_REFILL) && bus.mc_valid;
    assign idle_lookup = rdy && (state_q == S_IDLE) && !bus.flush && bus.fet_req;

    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.mc_ena      = mc_ena_q;
    assign bus.mc_addr     = mc_addr_q;

    // The LRU bit names the way to evict next: after touching a way, the other one
    function automatic logic other_way(input logic w);
        return (WAYS == 1) ? 1'b0 : ~w;
    endfunction

    // Tag compare across the ways of the addressed set, plus victim choice
    always_comb begin
        hit          = 1'b0;
        hit_way      = 1'b0;
        victim       = lru_q[req_idx];
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[req_idx][w[0]] && (tag_mem[req_idx][w[0]] == req_tag)) begin
                hit     = 1'b1;
                hit_way = w[0];
            end
            if (!victim_found && !valid_q[req_idx][w[0]]) begin
                victim       = w[0];
                victim_found = 1'b1;
            end
        end
        if (WAYS == 1) begin
            victim = 1'b0;
        end
    end

    // Control FSM: lookup in IDLE, line refill in REFILL, flush handling
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
            lru_q         <= '0;
            state_q       <= S_IDLE;
            beat_q        <= '0;
            ref_idx_q     <= '0;
            ref_way_q     <= 1'b0;
            flush_pend_q  <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            mc_ena_q      <= 1'b0;
            mc_addr_q     <= '0;
        end else if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.flush) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                        end
                        instr_valid_q <= 1'b0;
                    end else if (bus.fet_req) begin
                        if (hit) begin
                            instr_valid_q  <= 1'b1;
                            instr_q        <= data_mem[req_idx][hit_way][req_off];
                            lru_q[req_idx] <= other_way(hit_way);
                        end else begin
                            instr_valid_q            <= 1'b0;
                            valid_q[req_idx][victim] <= 1'b0;
                            ref_idx_q                <= req_idx;
                            ref_way_q                <= victim;
                            mc_ena_q                 <= 1'b1;
                            mc_addr_q                <= {bus.pc[31:2+OB], {(OB+2){1'b0}}};
                            beat_q                   <= '0;
                            state_q                  <= S_REFILL;
                        end
                    end else begin
                        instr_valid_q <= 1'b0;
                    end
                end

                S_REFILL: begin
                    instr_valid_q <= 1'b0;
                    if (bus.flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (bus.mc_valid) begin
                        if (!last_beat) begin
                            beat_q    <= beat_q + 1'b1;
                            mc_addr_q <= mc_addr_q + 32'd4;
                        end else begin
                            if (flush_pend_q || bus.flush) begin
                                for (int s = 0; s < SETS; s++) begin
                                    valid_q[s] <= '0;
                                end
                            end else begin
                                valid_q[ref_idx_q][ref_way_q] <= 1'b1;
                            end
                            flush_pend_q     <= 1'b0;
                            lru_q[ref_idx_q] <= other_way(ref_way_q);
                            mc_ena_q         <= 1'b0;
                            beat_q           <= '0;
                            state_q          <= S_IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data storage writes: tag on the miss edge, data on each refill beat
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (idle_lookup && !hit) begin
                tag_mem[req_idx][victim] <= req_tag;
            end
            if (beat_fire) begin
                data_mem[ref_idx_q][ref_way_q][beat_q] <= bus.mc_data;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    // Free-running hit/miss counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (idle_lookup) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
